// File: rtl/mem_access_stage.sv
// mem_access_stage: data-memory access stage of the 5-stage pipeline.
// Converts EX/MEM load/store controls into a registered req/ack memory
// transaction, stalls upstream while the access is in flight, flags
// misaligned word accesses and memory timeouts, and holds the MEM/WB
// pipeline register that feeds write-back.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  wb_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  writeaddr_i,
    output logic        stall_o,
    output logic        mreq_o,
    output logic        mwe_o,
    output logic [31:0] maddr_o,
    output logic [31:0] mwdata_o,
    input  logic        mack_i,
    input  logic [31:0] mrdata_i,
    output logic [1:0]  wb_o,
    output logic [31:0] rdata_o,
    output logic [31:0] result_o,
    output logic [4:0]  writeaddr_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last counter value of the wait window; the request lives for TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_timeout;
    logic [31:0] r_cap_data;

    logic        r_mreq;
    logic        r_mwe;
    logic [31:0] r_maddr;
    logic [31:0] r_mwdata;

    logic [1:0]  r_wb;
    logic [31:0] r_rdata;
    logic [31:0] r_result;
    logic [4:0]  r_writeaddr;
    logic        r_err;

    logic        w_access;
    logic        w_aligned;
    logic        w_start;

    // Decode the EX/MEM request; both controls high is treated as a store.
    always_comb begin
        w_access  = memread_i | memwrite_i;
        w_aligned = (addr_i[1:0] == 2'b00);
        w_start   = (r_state == S_IDLE) & w_access & w_aligned;
        stall_o   = ~rst_i & ((r_state == S_WAIT) | w_start);
    end

    // Access FSM, memory port registers and MEM/WB pipeline register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_timeout   <= 1'b0;
            r_cap_data  <= 32'd0;
            r_mreq      <= 1'b0;
            r_mwe       <= 1'b0;
            r_maddr     <= 32'd0;
            r_mwdata    <= 32'd0;
            r_wb        <= 2'b00;
            r_rdata     <= 32'd0;
            r_result    <= 32'd0;
            r_writeaddr <= 5'd0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_result    <= addr_i;
                    r_writeaddr <= writeaddr_i;
                    r_rdata     <= 32'd0;
                    if (!w_access) begin
                        r_wb <= wb_i;
                    end else if (!w_aligned) begin
                        // Misaligned word access: squash write-back, report error.
                        r_wb  <= 2'b00;
                        r_err <= 1'b1;
                    end else begin
                        r_wb     <= 2'b00;
                        r_mreq   <= 1'b1;
                        r_mwe    <= memwrite_i;
                        r_maddr  <= addr_i;
                        r_mwdata <= wdata_i;
                        r_cnt    <= 8'd0;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_wb <= 2'b00;
                    if (mack_i) begin
                        r_cap_data <= r_mwe ? 32'd0 : mrdata_i;
                        r_timeout  <= 1'b0;
                        r_mreq     <= 1'b0;
                        r_state    <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cap_data <= 32'd0;
                        r_timeout  <= 1'b1;
                        r_mreq     <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    // Same instruction is still presented; retire it into MEM/WB.
                    r_wb        <= r_timeout ? 2'b00 : wb_i;
                    r_rdata     <= r_cap_data;
                    r_result    <= addr_i;
                    r_writeaddr <= writeaddr_i;
                    r_err       <= r_timeout;
                    r_timeout   <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_mreq  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        mreq_o      = r_mreq;
        mwe_o       = r_mwe;
        maddr_o     = r_maddr;
        mwdata_o    = r_mwdata;
        wb_o        = r_wb;
        rdata_o     = r_rdata;
        result_o    = r_result;
        writeaddr_o = r_writeaddr;
        err_o       = r_err;
    end

endmodule
